// File: rtl/tour_cmd_seq.sv
// ----------------------------------------------------------------------------
// tour_cmd_seq
//   Replays a solved knight's tour as command-processor commands.
//   After start_tour, each one-hot move byte (addressed by indx) is split into
//   a vertical command and then a horizontal command. Each command is offered
//   on cmd/cmd_rdy until it is accepted, and then held until execution is
//   reported. In IDLE, UART commands pass straight through.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start_tour      1-clk pulse from the solver; starts a replay
//   move [7:0]      one-hot move at indx (combinational from the solver)
//   indx [4:0]      index of the move being replayed
//   cmd_UART [15:0] / cmd_rdy_UART   command from the UART wrapper
//   clr_cmd_rdy     clears the UART wrapper cmd_rdy (IDLE pass-through only)
//   cmd [15:0] / cmd_rdy             command to cmd_proc (combinational)
//   clr_cmd_rdy_in  cmd_proc accepted cmd
//   send_resp       cmd_proc finished executing cmd
//   resp [7:0]      registered response byte to the UART transmitter
// ----------------------------------------------------------------------------
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24,
  parameter logic [7:0]  POS_ACK   = 8'h5A,
  parameter logic [7:0]  DONE_ACK  = 8'hA5,
  parameter logic [7:0]  ERR_RESP  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy_in,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;

  localparam logic [3:0] OP_VERT  = 4'h2;
  localparam logic [3:0] OP_HORZ  = 4'h3;
  localparam logic [7:0] HDG_N    = 8'h00;
  localparam logic [7:0] HDG_S    = 8'h7F;
  localparam logic [7:0] HDG_E    = 8'hBF;
  localparam logic [7:0] HDG_W    = 8'h3F;

  typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    indx_q, indx_d;
  logic [RESP_W-1:0]   resp_q, resp_d;

  logic                dx_neg, dy_neg;
  logic [1:0]          dx_mag, dy_mag;
  logic [CMD_W-1:0]    cmd_vert, cmd_horz;
  logic                last_move;

  assign indx = indx_q;
  assign resp = resp_q;

  // Move decode: lowest set bit wins, giving signed (dx,dy) as sign + magnitude
  always_comb begin
    dx_neg = 1'b0;
    dx_mag = 2'd0;
    dy_neg = 1'b0;
    dy_mag = 2'd0;
    casez (move)
      8'b???????1: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'b??????10: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'b?????100: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      8'b????1000: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'b???10000: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'b??100000: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'b?1000000: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'b10000000: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      default:     begin dx_neg = 1'b0; dx_mag = 2'd0; dy_neg = 1'b0; dy_mag = 2'd0; end
    endcase
  end

  assign cmd_vert  = {OP_VERT, (dy_neg ? HDG_S : HDG_N), 2'b00, dy_mag};
  assign cmd_horz  = {OP_HORZ, (dx_neg ? HDG_W : HDG_E), 2'b00, dx_mag};
  assign last_move = (indx_q == IDX_W'(NUM_MOVES - 1));

  // State, move index and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      indx_q  <= '0;
      resp_q  <= DONE_ACK;
    end else begin
      state_q <= state_d;
      indx_q  <= indx_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state and command hand-off
  always_comb begin
    state_d     = state_q;
    indx_d      = indx_q;
    resp_d      = resp_q;
    cmd         = '0;
    cmd_rdy     = 1'b0;
    clr_cmd_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd         = cmd_UART;
        cmd_rdy     = cmd_rdy_UART;
        clr_cmd_rdy = clr_cmd_rdy_in;
        // Answer a pass-through command with the normal acknowledge
        if (send_resp) resp_d = DONE_ACK;
        if (start_tour) begin
          indx_d  = '0;
          state_d = VERT;
        end
      end
      VERT: begin
        // An empty move byte aborts the tour without issuing a command
        if (move == 8'h00) begin
          resp_d  = ERR_RESP;
          state_d = IDLE;
        end else begin
          cmd     = cmd_vert;
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy_in) state_d = HOLDV;
        end
      end
      HOLDV: begin
        cmd = cmd_vert;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = cmd_horz;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy_in) state_d = HOLDH;
      end
      HOLDH: begin
        cmd = cmd_horz;
        if (send_resp) begin
          if (last_move) begin
            resp_d  = DONE_ACK;
            state_d = IDLE;
          end else begin
            indx_d  = indx_q + IDX_W'(1);
            resp_d  = POS_ACK;
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_tour_cmd_seq
//   Directed bench for tour_cmd_seq. Expected commands are queued when a move
//   is set up and popped as the DUT offers each command; a small (dx,dy)
//   table model supplies the expected commands for randomised tours.
// ----------------------------------------------------------------------------
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_in;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  move_tab [32];
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  localparam int DXT [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  localparam int DYT [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

  tour_cmd_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_tour     (start_tour),
    .move           (move),
    .indx           (indx),
    .cmd_UART       (cmd_UART),
    .cmd_rdy_UART   (cmd_rdy_UART),
    .clr_cmd_rdy    (clr_cmd_rdy),
    .cmd            (cmd),
    .cmd_rdy        (cmd_rdy),
    .clr_cmd_rdy_in (clr_cmd_rdy_in),
    .send_resp      (send_resp),
    .resp           (resp)
  );

  always #5 clk = ~clk;

  // Solver model: move byte looked up combinationally from indx
  assign move = move_tab[indx];

  function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horz);
    int b;
    int d;
    b = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) b = i;
    if (horz) begin
      d = DXT[b];
      return {4'h3, ((d > 0) ? 8'hBF : 8'h3F), 4'((d < 0) ? -d : d)};
    end
    d = DYT[b];
    return {4'h2, ((d > 0) ? 8'h00 : 8'h7F), 4'((d < 0) ? -d : d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an offered command, check it, then accept it
  task automatic serve(input string tag);
    logic [15:0] e;
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " rdy"}, 32'(cmd_rdy), 32'h1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, " cmd"}, 32'(cmd), 32'(e));
    clr_cmd_rdy_in = 1'b1;
    #1;
    chk({tag, " clr_blocked"}, 32'(clr_cmd_rdy), 32'h0);
    tick();
    clr_cmd_rdy_in = 1'b0;
    #1;
    chk({tag, " held"}, 32'(cmd_rdy), 32'h0);
  endtask

  task automatic respond();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
  endtask

  task automatic run_pair();
    serve("vert");
    respond();
    serve("horz");
    respond();
  endtask

  task automatic do_move(input int k);
    exp_q.push_back(model_cmd(move_tab[k], 1'b0));
    exp_q.push_back(model_cmd(move_tab[k], 1'b1));
    run_pair();
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = '0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy_in = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < 32; i++) move_tab[i] = 8'h00;
    do_reset();
    chk("rst indx", 32'(indx), 32'h0);
    chk("rst resp", 32'(resp), 32'hA5);
    chk("rst cmd_rdy", 32'(cmd_rdy), 32'h0);

    // Pass-through in IDLE
    cmd_UART = 16'h2013; cmd_rdy_UART = 1'b1;
    #1;
    chk("pt cmd", 32'(cmd), 32'h2013);
    chk("pt cmd_rdy", 32'(cmd_rdy), 32'h1);
    clr_cmd_rdy_in = 1'b1;
    #1;
    chk("pt clr", 32'(clr_cmd_rdy), 32'h1);
    tick();
    clr_cmd_rdy_in = 1'b0; cmd_rdy_UART = 1'b0;
    #1;

    // Single move: north 2, then east 1 with fanfare
    move_tab[0] = 8'h02;
    pulse_start();
    chk("t3 indx0", 32'(indx), 32'h0);
    exp_q.push_back(16'h2002);
    exp_q.push_back(16'h3BF1);
    run_pair();
    chk("t3 resp", 32'(resp), 32'h5A);
    chk("t3 indx", 32'(indx), 32'h1);
    do_reset();

    // Decode sweep
    move_tab[0] = 8'h08; move_tab[1] = 8'h40;
    pulse_start();
    exp_q.push_back(16'h27F1); exp_q.push_back(16'h33F2);
    exp_q.push_back(16'h27F1); exp_q.push_back(16'h3BF2);
    run_pair();
    run_pair();
    chk("t4 resp", 32'(resp), 32'h5A);
    chk("t4 indx", 32'(indx), 32'h2);
    do_reset();

    // Random tour table, with a few multi-bit bytes to exercise priority
    for (int i = 0; i < 24; i++) move_tab[i] = 8'(32'h1 << $urandom_range(0, 7));
    move_tab[5] = 8'h06; move_tab[9] = 8'hC0; move_tab[12] = 8'h81;
    move_tab[24] = 8'h00;

    // Reset mid-tour while in HOLDH at indx 7
    pulse_start();
    for (int k = 0; k < 7; k++) do_move(k);
    exp_q.push_back(model_cmd(move_tab[7], 1'b0));
    exp_q.push_back(model_cmd(move_tab[7], 1'b1));
    serve("t1 vert");
    respond();
    serve("t1 horz");
    chk("t1 indx7", 32'(indx), 32'h7);
    cmd_rdy_UART = 1'b1;
    do_reset();
    chk("t1 indx", 32'(indx), 32'h0);
    chk("t1 resp", 32'(resp), 32'hA5);
    chk("t1 cmd_rdy follows", 32'(cmd_rdy), 32'h1);
    cmd_rdy_UART = 1'b0;
    #1;
    chk("t1 cmd_rdy low", 32'(cmd_rdy), 32'h0);

    // Full tour, then a replay from indx 0
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      do_move(k);
      if (k < 23) begin
        chk("t5 resp pos", 32'(resp), 32'h5A);
        chk("t5 indx", 32'(indx), 32'(k + 1));
      end
    end
    chk("t5 resp done", 32'(resp), 32'hA5);
    chk("t5 indx last", 32'(indx), 32'd23);
    chk("t5 queue empty", 32'(exp_q.size()), 32'h0);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    #1;
    chk("t5 idle cmd", 32'(cmd), 32'h1234);
    chk("t5 idle rdy", 32'(cmd_rdy), 32'h1);
    cmd_rdy_UART = 1'b0;
    #1;
    pulse_start();
    chk("t5 replay indx", 32'(indx), 32'h0);
    do_move(0);
    chk("t5 replay resp", 32'(resp), 32'h5A);
    chk("t5 replay indx1", 32'(indx), 32'h1);
    do_reset();

    // Protocol abuse
    move_tab[0] = 8'h10; move_tab[1] = 8'h00;
    pulse_start();
    cmd_rdy_UART = 1'b1;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    chk("t6 early resp ignored", 32'(cmd_rdy), 32'h1);
    chk("t6 vert cmd", 32'(cmd), 32'h27F2);
    clr_cmd_rdy_in = 1'b1; send_resp = 1'b1;
    #1;
    chk("t6 clr held", 32'(clr_cmd_rdy), 32'h0);
    tick();
    clr_cmd_rdy_in = 1'b0; send_resp = 1'b0;
    #1;
    chk("t6 accept only", 32'(cmd_rdy), 32'h0);
    pulse_start();
    chk("t6 start ignored rdy", 32'(cmd_rdy), 32'h0);
    chk("t6 start ignored indx", 32'(indx), 32'h0);
    respond();
    chk("t6 horz rdy", 32'(cmd_rdy), 32'h1);
    chk("t6 horz cmd", 32'(cmd), 32'h33F1);
    clr_cmd_rdy_in = 1'b1;
    tick();
    clr_cmd_rdy_in = 1'b0;
    respond();
    chk("t6 pos resp", 32'(resp), 32'h5A);
    chk("t6 indx1", 32'(indx), 32'h1);
    chk("t6 empty no cmd", 32'(cmd_rdy), 32'h0);
    tick();
    chk("t6 err resp", 32'(resp), 32'hEE);
    chk("t6 idle rdy", 32'(cmd_rdy), 32'h1);
    cmd_rdy_UART = 1'b0;
    respond();
    chk("t6 idle ack", 32'(resp), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
